// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-word controller.
// Holds the FSM state encoding, step lookup and default word limits.
package dds_ctrl_pkg;

    localparam int FW_DEF        = 24;
    localparam int F_DEFAULT_DEF = 1678;
    localparam int F_MIN_DEF     = 168;
    localparam int F_MAX_DEF     = 3355443;

    localparam logic [9:0] STEP_1    = 10'd1;
    localparam logic [9:0] STEP_10   = 10'd10;
    localparam logic [9:0] STEP_100  = 10'd100;
    localparam logic [9:0] STEP_1000 = 10'd1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC3  = 2'd1,
        ST_CALC5  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    function automatic logic [9:0] step_of(input logic [1:0] sel);
        logic [9:0] s;
        case (sel)
            2'd0:    s = STEP_1;
            2'd1:    s = STEP_10;
            2'd2:    s = STEP_100;
            default: s = STEP_1000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dds_sweep_timer.sv
// Sweep tick generator: counts 0..SWEEP_DIV-1 while enabled and raises a
// sticky pending flag on each wrap until the controller acknowledges it.
module dds_sweep_timer #(
    parameter int SWEEP_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ack,
    output logic pending
);

    localparam int CW = $clog2(SWEEP_DIV);
    localparam logic [CW-1:0] CNT_TC = CW'(SWEEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          tc;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        tc        = (cnt_q == CNT_TC);
        if (!en) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
            // A fresh wrap outranks an acknowledge landing in the same cycle.
            if (tc) begin
                pending_d = 1'b1;
            end else if (ack) begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/dds_freq_ctrl.sv
// Frequency-word controller: key commands and sweep ticks produce a new
// fundamental, 3x and 5x are built on one shared adder, then committed at once.
//
// state     | meaning
// ST_IDLE   | waiting for a key command or pending sweep tick
// ST_CALC3  | shared adder forms 3*f_new
// ST_CALC5  | shared adder forms 5*f_new
// ST_COMMIT | load all three words, pulse upd
module dds_freq_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FW        = FW_DEF,
    parameter int F_DEFAULT = F_DEFAULT_DEF,
    parameter int F_MIN     = F_MIN_DEF,
    parameter int F_MAX     = F_MAX_DEF,
    parameter int SWEEP_DIV = 500000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          k0,
    input  logic          k1,
    input  logic          k2,
    input  logic          k3,
    input  logic          k4,
    input  logic          k5,
    output logic [FW-1:0] freq_word,
    output logic [FW-1:0] freq_word_3,
    output logic [FW-1:0] freq_word_5,
    output logic          upd,
    output logic          busy,
    output logic          sweeping,
    output logic [1:0]    step_sel
);

    localparam logic [FW-1:0] F_DEF_W  = FW'(F_DEFAULT);
    localparam logic [FW-1:0] F_DEF3_W = FW'(3 * F_DEFAULT);
    localparam logic [FW-1:0] F_DEF5_W = FW'(5 * F_DEFAULT);
    localparam logic [FW-1:0] F_MIN_W  = FW'(F_MIN);
    localparam logic [FW-1:0] F_MAX_W  = FW'(F_MAX);

    state_e        state_q, state_d;
    logic [FW-1:0] f_lat_q, f_lat_d;
    logic [FW-1:0] p3_q, p3_d;
    logic [FW-1:0] p5_q, p5_d;
    logic [FW-1:0] fw_q, fw_d;
    logic [FW-1:0] fw3_q, fw3_d;
    logic [FW-1:0] fw5_q, fw5_d;
    logic          upd_q, upd_d;
    logic          busy_q, busy_d;
    logic          sweeping_q, sweeping_d;
    logic [1:0]    step_sel_q, step_sel_d;

    logic          tick_pending;
    logic          tick_ack;
    logic [FW-1:0] step_w;
    logic [FW:0]   up_sum;
    logic [FW-1:0] f_up_sat;
    logic [FW-1:0] f_dn_sat;
    logic [FW-1:0] f_sweep;
    logic [FW-1:0] f_new;
    logic          cmd_valid;
    logic [FW-1:0] add_b;
    logic [FW-1:0] add_sum;

    dds_sweep_timer #(
        .SWEEP_DIV (SWEEP_DIV)
    ) u_sweep_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sweeping_q),
        .ack     (tick_ack),
        .pending (tick_pending)
    );

    // Candidate next words, all derived from the committed fundamental.
    always_comb begin
        step_w   = FW'(step_of(step_sel_q));
        up_sum   = {1'b0, fw_q} + {1'b0, step_w};
        f_up_sat = (up_sum > {1'b0, F_MAX_W}) ? F_MAX_W : up_sum[FW-1:0];
        f_sweep  = (up_sum > {1'b0, F_MAX_W}) ? F_MIN_W : up_sum[FW-1:0];
        f_dn_sat = (fw_q >= (F_MIN_W + step_w)) ? (fw_q - step_w) : F_MIN_W;
    end

    // Single adder; the FSM only picks which shift of f_lat feeds it.
    assign add_sum = f_lat_q + add_b;

    always_comb begin
        state_d   = state_q;
        f_lat_d   = f_lat_q;
        p3_d      = p3_q;
        p5_d      = p5_q;
        fw_d      = fw_q;
        fw3_d     = fw3_q;
        fw5_d     = fw5_q;
        upd_d     = 1'b0;
        tick_ack  = 1'b0;
        cmd_valid = 1'b0;
        f_new     = fw_q;
        add_b     = f_lat_q << 1;

        case (state_q)
            ST_IDLE: begin
                if (k3) begin
                    f_new     = F_DEF_W;
                    cmd_valid = 1'b1;
                end else if (k0 ^ k1) begin
                    f_new     = k0 ? f_up_sat : f_dn_sat;
                    cmd_valid = 1'b1;
                end else if (tick_pending && sweeping_q) begin
                    f_new     = f_sweep;
                    cmd_valid = 1'b1;
                    tick_ack  = 1'b1;
                end
                if (cmd_valid && (f_new != fw_q)) begin
                    f_lat_d = f_new;
                    state_d = ST_CALC3;
                end
            end
            ST_CALC3: begin
                add_b   = f_lat_q << 1;
                p3_d    = add_sum;
                state_d = ST_CALC5;
            end
            ST_CALC5: begin
                add_b   = f_lat_q << 2;
                p5_d    = add_sum;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                fw_d    = f_lat_q;
                fw3_d   = p3_q;
                fw5_d   = p5_q;
                upd_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        step_sel_d = k2 ? step_sel_q + 2'd1 : step_sel_q;
        sweeping_d = k5 ? 1'b0 : (k4 ? 1'b1 : sweeping_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            f_lat_q    <= F_DEF_W;
            p3_q       <= F_DEF3_W;
            p5_q       <= F_DEF5_W;
            fw_q       <= F_DEF_W;
            fw3_q      <= F_DEF3_W;
            fw5_q      <= F_DEF5_W;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            sweeping_q <= 1'b0;
            step_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            f_lat_q    <= f_lat_d;
            p3_q       <= p3_d;
            p5_q       <= p5_d;
            fw_q       <= fw_d;
            fw3_q      <= fw3_d;
            fw5_q      <= fw5_d;
            upd_q      <= upd_d;
            busy_q     <= busy_d;
            sweeping_q <= sweeping_d;
            step_sel_q <= step_sel_d;
        end
    end

    assign freq_word   = fw_q;
    assign freq_word_3 = fw3_q;
    assign freq_word_5 = fw5_q;
    assign upd         = upd_q;
    assign busy        = busy_q;
    assign sweeping    = sweeping_q;
    assign step_sel    = step_sel_q;

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Directed bench for dds_freq_ctrl: default instance for key handling and
// reset, a short-period low-F_MAX instance for sweep wrap.
module tb_dds_freq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        k0, k1, k2, k3, k4, k5;
    logic [23:0] fw, fw3, fw5;
    logic        upd, busy, sweeping;
    logic [1:0]  step_sel;

    logic        s_k0, s_k1, s_k2, s_k3, s_k4, s_k5;
    logic [23:0] s_fw, s_fw3, s_fw5;
    logic        s_upd, s_busy, s_sweeping;
    logic [1:0]  s_step_sel;

    int checks = 0;
    int errors = 0;

    dds_freq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5),
        .freq_word(fw), .freq_word_3(fw3), .freq_word_5(fw5),
        .upd(upd), .busy(busy), .sweeping(sweeping), .step_sel(step_sel)
    );

    dds_freq_ctrl #(
        .SWEEP_DIV (8),
        .F_MAX     (1700)
    ) dut_s (
        .clk(clk), .rst_n(rst_n),
        .k0(s_k0), .k1(s_k1), .k2(s_k2), .k3(s_k3), .k4(s_k4), .k5(s_k5),
        .freq_word(s_fw), .freq_word_3(s_fw3), .freq_word_5(s_fw5),
        .upd(s_upd), .busy(s_busy), .sweeping(s_sweeping), .step_sel(s_step_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle key pulse starting at a falling edge; returns at the
    // falling edge just after the rising edge that sampled it.
    task automatic pulse(input logic [5:0] keys, input logic [5:0] s_keys);
        {k5, k4, k3, k2, k1, k0} = keys;
        {s_k5, s_k4, s_k3, s_k2, s_k1, s_k0} = s_keys;
        @(negedge clk);
        {k5, k4, k3, k2, k1, k0} = '0;
        {s_k5, s_k4, s_k3, s_k2, s_k1, s_k0} = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        {k5, k4, k3, k2, k1, k0} = '0;
        {s_k5, s_k4, s_k3, s_k2, s_k1, s_k0} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fw !== 24'd1678) begin errors++; $display("FAIL reset_fw got %0d exp 1678", fw); end
        checks++; if (fw3 !== 24'd5034) begin errors++; $display("FAIL reset_fw3 got %0d exp 5034", fw3); end
        checks++; if (fw5 !== 24'd8390) begin errors++; $display("FAIL reset_fw5 got %0d exp 8390", fw5); end
        checks++; if ({upd, busy, sweeping} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {upd, busy, sweeping}); end
        checks++; if (step_sel !== 2'd0) begin errors++; $display("FAIL reset_step_sel got %0d exp 0", step_sel); end
        checks++; if (s_fw !== 24'd1678) begin errors++; $display("FAIL reset_s_fw got %0d exp 1678", s_fw); end
    endtask

    task automatic test_step_up;
        pulse(6'b000001, 6'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_n0 got %b exp 1", busy); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL up_upd_early got %b exp 0", upd); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_n2 got %b exp 1", busy); end
        checks++; if (fw !== 24'd1678) begin errors++; $display("FAIL up_fw_held got %0d exp 1678", fw); end
        @(negedge clk);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL up_upd got %b exp 1", upd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_n3 got %b exp 0", busy); end
        checks++; if (fw !== 24'd1679) begin errors++; $display("FAIL up_fw got %0d exp 1679", fw); end
        checks++; if (fw3 !== 24'd5037) begin errors++; $display("FAIL up_fw3 got %0d exp 5037", fw3); end
        checks++; if (fw5 !== 24'd8395) begin errors++; $display("FAIL up_fw5 got %0d exp 8395", fw5); end
        @(negedge clk);
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL up_upd_width got %b exp 0", upd); end
    endtask

    task automatic test_step_sat;
        int n_upd;
        pulse(6'b000100, 6'b0);
        checks++; if (step_sel !== 2'd1) begin errors++; $display("FAIL sat_step1 got %0d exp 1", step_sel); end
        pulse(6'b000100, 6'b0);
        pulse(6'b000100, 6'b0);
        checks++; if (step_sel !== 2'd3) begin errors++; $display("FAIL sat_step3 got %0d exp 3", step_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_k2_busy got %b exp 0", busy); end
        pulse(6'b000010, 6'b0);
        repeat (3) @(negedge clk);
        checks++; if (fw !== 24'd679) begin errors++; $display("FAIL sat_dn1 got %0d exp 679", fw); end
        checks++; if (fw5 !== 24'd3395) begin errors++; $display("FAIL sat_dn1_fw5 got %0d exp 3395", fw5); end
        @(negedge clk);
        pulse(6'b000010, 6'b0);
        repeat (3) @(negedge clk);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL sat_dn2_upd got %b exp 1", upd); end
        checks++; if (fw !== 24'd168) begin errors++; $display("FAIL sat_dn2 got %0d exp 168", fw); end
        checks++; if (fw3 !== 24'd504) begin errors++; $display("FAIL sat_dn2_fw3 got %0d exp 504", fw3); end
        checks++; if (fw5 !== 24'd840) begin errors++; $display("FAIL sat_dn2_fw5 got %0d exp 840", fw5); end
        @(negedge clk);
        pulse(6'b000010, 6'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_floor_busy got %b exp 0", busy); end
        n_upd = 0;
        repeat (6) begin
            @(negedge clk);
            if (upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL sat_floor_upd got %0d exp 0", n_upd); end
        checks++; if (fw !== 24'd168) begin errors++; $display("FAIL sat_floor_fw got %0d exp 168", fw); end
    endtask

    task automatic test_busy_keys;
        int n_upd;
        pulse(6'b000011, 6'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_busy got %b exp 0", busy); end
        n_upd = 0;
        repeat (5) begin
            @(negedge clk);
            if (upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL both_upd got %0d exp 0", n_upd); end
        pulse(6'b000001, 6'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_first got %b exp 1", busy); end
        pulse(6'b000001, 6'b0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL busy_upd got %b exp 1", upd); end
        checks++; if (fw !== 24'd1168) begin errors++; $display("FAIL busy_fw got %0d exp 1168", fw); end
        checks++; if (fw3 !== 24'd3504) begin errors++; $display("FAIL busy_fw3 got %0d exp 3504", fw3); end
        checks++; if (fw5 !== 24'd5840) begin errors++; $display("FAIL busy_fw5 got %0d exp 5840", fw5); end
        n_upd = 0;
        repeat (8) begin
            @(negedge clk);
            if (upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL busy_dropped got %0d exp 0", n_upd); end
        checks++; if (fw !== 24'd1168) begin errors++; $display("FAIL busy_fw_final got %0d exp 1168", fw); end
    endtask

    task automatic test_sweep_wrap;
        logic [23:0] exp_fw [3];
        int exp_gap [3];
        int gap;
        int n_upd;
        exp_fw[0] = 24'd1688; exp_fw[1] = 24'd1698; exp_fw[2] = 24'd168;
        exp_gap[0] = 12; exp_gap[1] = 8; exp_gap[2] = 8;
        pulse(6'b0, 6'b000100);
        checks++; if (s_step_sel !== 2'd1) begin errors++; $display("FAIL sw_step got %0d exp 1", s_step_sel); end
        pulse(6'b0, 6'b010000);
        checks++; if (s_sweeping !== 1'b1) begin errors++; $display("FAIL sw_on got %b exp 1", s_sweeping); end
        for (int t = 0; t < 3; t++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (s_upd !== 1'b1 && gap < 40);
            checks++; if (gap !== exp_gap[t]) begin errors++; $display("FAIL sw_gap%0d got %0d exp %0d", t, gap, exp_gap[t]); end
            checks++; if (s_fw !== exp_fw[t]) begin errors++; $display("FAIL sw_fw%0d got %0d exp %0d", t, s_fw, exp_fw[t]); end
        end
        checks++; if (s_fw3 !== 24'd504) begin errors++; $display("FAIL sw_wrap_fw3 got %0d exp 504", s_fw3); end
        checks++; if (s_fw5 !== 24'd840) begin errors++; $display("FAIL sw_wrap_fw5 got %0d exp 840", s_fw5); end
        pulse(6'b0, 6'b100000);
        checks++; if (s_sweeping !== 1'b0) begin errors++; $display("FAIL sw_off got %b exp 0", s_sweeping); end
        n_upd = 0;
        repeat (30) begin
            @(negedge clk);
            if (s_upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL sw_stopped got %0d exp 0", n_upd); end
        checks++; if (s_fw !== 24'd168) begin errors++; $display("FAIL sw_final got %0d exp 168", s_fw); end
    endtask

    task automatic test_reset_mid;
        int n_upd;
        pulse(6'b010000, 6'b0);
        checks++; if (sweeping !== 1'b1) begin errors++; $display("FAIL rm_sweep_on got %b exp 1", sweeping); end
        pulse(6'b000001, 6'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_in_calc got %b exp 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (fw !== 24'd1678) begin errors++; $display("FAIL rm_fw got %0d exp 1678", fw); end
        checks++; if (fw3 !== 24'd5034) begin errors++; $display("FAIL rm_fw3 got %0d exp 5034", fw3); end
        checks++; if (fw5 !== 24'd8390) begin errors++; $display("FAIL rm_fw5 got %0d exp 8390", fw5); end
        checks++; if ({upd, busy, sweeping} !== 3'b000) begin errors++; $display("FAIL rm_flags got %b exp 000", {upd, busy, sweeping}); end
        checks++; if (step_sel !== 2'd0) begin errors++; $display("FAIL rm_step got %0d exp 0", step_sel); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_upd = 0;
        repeat (6) begin
            @(negedge clk);
            if (upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL rm_no_partial got %0d exp 0", n_upd); end
        checks++; if (fw !== 24'd1678) begin errors++; $display("FAIL rm_fw_after got %0d exp 1678", fw); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_step_sat();
        test_busy_keys();
        test_sweep_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
